// File: rtl/data_memory_if.sv
// data_memory_if: request/response bundle between the core memory stage
// (master) and the data memory (slave).
//   req_valid/req_ready : request handshake, accepted when both are high
//   req_we              : 1 = store, 0 = load
//   req_size            : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        : loads only, 1 = zero-extend
//   addr                : byte address
//   wdata               : store data (low bytes used for byte/half)
//   rsp_valid           : one-cycle response pulse
//   rdata               : extended load data, 0 for stores and errors
//   err                 : request was misaligned, out of range or illegal
interface data_memory_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic                  rsp_valid;
  logic [31:0]           rdata;
  logic                  err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, addr, wdata,
    input  req_ready, rsp_valid, rdata, err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, addr, wdata,
    output req_ready, rsp_valid, rdata, err
  );
endinterface

// File: rtl/data_memory.sv
// data_memory: byte-addressed data memory with RISC-V byte/half/word
// loads and stores, sign/zero extension, misalignment and range checks.
// After reset the array is cleared one word per cycle (INIT); requests are
// then accepted one per cycle and answered with a registered response one
// cycle later.
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : data_memory_if slave port (request + response)
module data_memory #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  data_memory_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {INIT, READY} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] cnt_reg, cnt_next;

  // request decode
  logic             accept;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             misaligned;
  logic             out_of_range;
  logic             err_d;
  logic             store_en;
  logic [3:0]       be;
  logic [31:0]      wdata_rep;

  // response registers
  logic             rsp_valid_reg;
  logic             err_reg;
  logic             load_ok_reg;
  logic [1:0]       size_reg;
  logic [1:0]       lane_reg;
  logic             unsigned_reg;
  logic [31:0]      rd_word;
  logic [31:0]      ext;

  assign bus.req_ready = (state_reg == READY);
  assign accept        = bus.req_valid && (state_reg == READY);

  always_comb begin
    idx          = bus.addr[IDX_W+1:2];
    lane         = bus.addr[1:0];
    // any set bit above the word index means the address is past the array,
    // so out-of-range addresses can never alias onto a valid word
    out_of_range = |bus.addr[ADDR_WIDTH-1:IDX_W+2];
    misaligned   = ((bus.req_size == 2'b01) && lane[0]) ||
                   ((bus.req_size == 2'b10) && (lane != 2'b00));
    err_d        = misaligned || out_of_range || (bus.req_size == 2'b11);
    be           = 4'hF;
    wdata_rep    = bus.wdata;
    // replicate the store data across lanes so each lane simply picks its
    // own byte; the byte enables decide which lanes actually write
    case (bus.req_size)
      2'b00: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << lane;
        wdata_rep = {2{bus.wdata[15:0]}};
      end
      default: begin
        be        = 4'hF;
        wdata_rep = bus.wdata;
      end
    endcase
    store_en = accept && bus.req_we && !err_d;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      INIT: begin
        cnt_next = cnt_reg + IDX_W'(1);
        if (cnt_reg == IDX_W'(DEPTH - 1)) begin
          state_next = READY;
        end
      end
      READY: begin
        state_next = READY;
      end
      default: begin
        state_next = INIT;
        cnt_next   = '0;
      end
    endcase
  end

  // ------------------------------------------------------ storage lanes
  // One byte-wide array per lane so byte/half stores map onto per-lane
  // write enables; reads are registered on the acceptance edge.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clk) begin
        if (state_reg == INIT) begin
          mem[cnt_reg] <= '0;
        end else if (store_en && be[gi]) begin
          mem[idx] <= wdata_rep[8*gi +: 8];
        end
        if (accept) begin
          rd_byte_reg <= mem[idx];
        end
      end

      assign rd_word[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

  // ----------------------------------------------------------- response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      load_ok_reg   <= 1'b0;
      size_reg      <= 2'b00;
      lane_reg      <= 2'b00;
      unsigned_reg  <= 1'b0;
    end else begin
      rsp_valid_reg <= accept;
      if (accept) begin
        err_reg      <= err_d;
        load_ok_reg  <= !bus.req_we && !err_d;
        size_reg     <= bus.req_size;
        lane_reg     <= lane;
        unsigned_reg <= bus.req_unsigned;
      end
    end
  end

  // lane select and extension act on the registered word, so rdata is a
  // pure function of registers captured at acceptance and holds afterwards
  always_comb begin
    ext = rd_word;
    case (size_reg)
      2'b00: begin
        ext[7:0]  = rd_word[8*lane_reg +: 8];
        ext[31:8] = unsigned_reg ? 24'h0 : {24{ext[7]}};
      end
      2'b01: begin
        ext[15:0]  = lane_reg[1] ? rd_word[31:16] : rd_word[15:0];
        ext[31:16] = unsigned_reg ? 16'h0 : {16{ext[15]}};
      end
      default: ext = rd_word;
    endcase
  end

  // stores, errors and the post-reset state all read back as zero
  assign bus.rdata     = load_ok_reg ? ext : 32'h0;
  assign bus.err       = err_reg;
  assign bus.rsp_valid = rsp_valid_reg;

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Parametrised successor to the single-cycle word memory used by the datapath.
- Byte-addressed data memory with RISC-V load/store sizes (byte/half/word), sign/zero extension, misalignment and range checking.
- Valid/ready request interface and a registered one-cycle read response.
- Self-clearing initialisation sequence after reset; sits between the core's memory stage and the load writeback mux.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, minimum 4.
- ADDR_WIDTH, 32, width of the byte address port.
- IDX_W, $clog2(DEPTH), word-index width; derived, not overridden.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend (LBU/LHU), 0 = sign-extend.
- addr  in  ADDR_WIDTH  byte address.
- wdata  in  32  store data; the low bytes are used for byte and half stores.
- rsp_valid  out  1  one-cycle pulse, one cycle after acceptance.
- rdata  out  32  extended load data; 0 for stores and errors.
- err  out  1  valid with rsp_valid; request was misaligned, out of range or illegal size.

Behaviour:
- States: INIT, READY.
- Reset (rst_n low, asynchronous):
  - State goes to INIT and the clear counter goes to 0.
  - rsp_valid = 0, rdata = 0, err = 0, req_ready = 0.
  - Memory array is not reset directly.
- INIT:
  - One word per cycle: mem[cnt] <= 0, then cnt++.
  - After the cycle that writes mem[DEPTH-1], state goes to READY. INIT lasts exactly DEPTH cycles after rst_n deasserts.
  - req_ready = 0 throughout INIT; requests are ignored, not queued.
- READY:
  - req_ready = 1 (combinational from state).
  - A request is accepted on an edge where req_valid && req_ready. One request per cycle with no bubbles.
- Decode:
  - idx = addr[IDX_W+1:2]; lane = addr[1:0].
  - Misaligned: half with lane[0] = 1, or word with lane != 0.
  - Out of range: addr >= DEPTH*4.
  - err_d = misaligned | out of range | size == 11.
- Store, accepted with err_d = 0:
  - Written on the same edge as acceptance.
  - Byte: only byte lane `lane` gets wdata[7:0].
  - Half: lanes lane and lane+1 get wdata[15:0].
  - Word: full write.
  - Other bytes of the word are unchanged.
- Store with err_d = 1: no memory write.
- Load:
  - On the acceptance edge, rdata is registered from the selected lane(s) of mem[idx].
  - Sign-extended from bit 7/15 unless req_unsigned = 1. Word loads ignore req_unsigned.
- Response:
  - The edge after acceptance sees rsp_valid = 1 with rdata and err.
  - Without a new acceptance, rsp_valid returns to 0 on the next edge; rdata and err are then don't-care (implementation holds them).
- Back-to-back ordering: a load accepted the cycle after a store to the same word returns the post-store value. Same-cycle collisions are impossible because there is one request per cycle.
- Reset mid-operation: a pending response is dropped (rsp_valid cleared immediately) and INIT restarts from cnt = 0, so all contents are re-zeroed.
- Index arithmetic wraps only through the range check; out-of-range addresses never alias onto valid words.

Test Plan:
1. Reset, then hold req_valid = 1 → req_ready stays 0 for exactly DEPTH (256) cycles, then rises. A word load at 0x3FC returns rdata = 0, err = 0.
2. SW 0x8000_00F1 @0x00C, then LW @0x00C → rsp_valid pulses 1 cycle after each acceptance; load rdata = 0x8000_00F1. Back-to-back store→load with no idle cycle.
3. SB 0xAB @0x011, SH 0xBEEF @0x012 on a word preset to 0 → LW @0x010 = 0xBEEF_AB00. LB @0x011 = 0xFFFF_FFAB. LBU @0x011 = 0x0000_00AB. LH @0x012 = 0xFFFF_BEEF. LHU @0x012 = 0x0000_BEEF.
4. SW 0x1234_5678 @0x020, then SW @0x022, LH @0x021, LW @0x400 (DEPTH = 256), and a size = 11 request → each response has err = 1 and rdata = 0. LW @0x020 still returns 0x1234_5678.
5. Issue LW @0x004 and pull rst_n low in the cycle before its response → rsp_valid never asserts. INIT reruns for 256 cycles, after which LW @0x020 returns 0.
6. Continuous stream of 16 alternating SW/LW to random aligned in-range addresses, checked against a scoreboard model → 16 responses, one per cycle after acceptance, all matching, err = 0.
